// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the serial-pattern detector.
//   state_e          controller state encoding (IDLE / RUN / DONE)
//   DEFAULT_PATTERN  pattern loaded at reset
//   DEFAULT_LEN      pattern length loaded at reset (clamped to PAT_W by users)
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;
  localparam int         DEFAULT_LEN     = 4;

endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: host/config and serial-bit bundle of the pattern detector.
//   master : drives cfg_valid/cfg_pattern/cfg_len/cfg_target, start, stop,
//            bit_valid, bit_in; observes cfg_ready, match, match_cnt, busy, done
//   slave  : the detector controller (opposite directions)
interface seq_det_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             stop;
  logic             bit_valid;
  logic             bit_in;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, start, stop, bit_valid, bit_in,
    input  cfg_ready, match, match_cnt, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, start, stop, bit_valid, bit_in,
    output cfg_ready, match, match_cnt, busy, done
  );
endinterface

// File: rtl/seq_det_shift.sv
// seq_det_shift: bit history, fill counter and masked pattern compare.
//   clk, clr   clock, async active-high reset
//   shift_en   accept bit_in into the history this cycle
//   restart    clear history and fill (wins over shift_en)
//   bit_in     serial data bit
//   pattern    pattern to match, bit[len-1] oldest
//   len        effective pattern length (already normalised to 1..PAT_W)
//   hit        combinational: history plus bit_in completes the pattern
module seq_det_shift import seq_det_pkg::*; #(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             restart,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] history_q, history_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;

  always_comb begin
    window = {history_q[PAT_W-2:0], bit_in};
    mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    // fill counts bits seen so far; the current bit supplies the last one
    hit = ((window & mask) == (pattern & mask)) && (int'(fill_q) >= int'(len) - 1);

    history_d = history_q;
    fill_d    = fill_q;
    if (restart) begin
      history_d = '0;
      fill_d    = '0;
    end else if (shift_en) begin
      history_d = window;
      if (int'(fill_q) < PAT_W) fill_d = fill_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      history_q <= '0;
      fill_q    <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial-pattern detector controller.
//   clk, clr   clock, async active-high reset
//   bus        seq_det_if.slave: config handshake, start/stop, bit stream,
//              match (combinational), match_cnt, busy, done, cfg_ready
// Build option: SEQ_DET_OVERLAP_EN keeps history after a match so matches
// may overlap; otherwise detection restarts from an empty history.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting; config accepted, start enters RUN
// RUN     | shifting qualified bits, counting matches
// DONE    | target reached; config accepted, start re-enters RUN
module seq_det_ctrl import seq_det_pkg::*; #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input logic     clk,
  input logic     clr,
  seq_det_if.slave bus
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'((PAT_W < DEFAULT_LEN) ? PAT_W : DEFAULT_LEN);
  localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_PATTERN);
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic             cfg_accept;
  logic             run_entry;
  logic             bit_match;
  logic             shift_restart;
  logic             hit;
  logic [LEN_W-1:0] len_norm;

  seq_det_shift #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_shift (
    .clk      (clk),
    .clr      (clr),
    .shift_en ((state_q == ST_RUN) && bus.bit_valid),
    .restart  (shift_restart),
    .bit_in   (bus.bit_in),
    .pattern  (pattern_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_comb begin
    if (bus.cfg_len == '0)                len_norm = LEN_W'(1);
    else if (int'(bus.cfg_len) > PAT_W)   len_norm = LEN_W'(PAT_W);
    else                                  len_norm = bus.cfg_len;

    // a config handshake swallows a simultaneous start
    cfg_accept    = bus.cfg_valid && (state_q != ST_RUN);
    run_entry     = (state_q != ST_RUN) && bus.start && !cfg_accept;
    bit_match     = (state_q == ST_RUN) && bus.bit_valid && hit;
    shift_restart = run_entry || (bit_match && !OVERLAP);

    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    target_d  = target_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bit_match) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if ((target_q != '0) &&
              (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, target_q}))
            state_d = ST_DONE;
        end
      end
      default: begin
        if (cfg_accept) begin
          pattern_d = bus.cfg_pattern;
          len_d     = len_norm;
          target_d  = bus.cfg_target;
        end else if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
    endcase

    busy_d      = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    cfg_ready_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      pattern_q   <= RST_PAT;
      len_q       <= RST_LEN;
      target_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign bus.match     = bit_match;
  assign bus.match_cnt = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed bench for seq_det_ctrl. Expected matches are queued
// by the driver; a monitor pops one whenever the DUT raises match and checks
// the bit index and the match count on the following cycle.
// Honours SEQ_DET_OVERLAP_EN for the overlap-dependent expectations.
module tb_seq_det_ctrl;

  logic clk;
  logic clr;

  seq_det_if #(.PAT_W(4), .CNT_W(8)) sif ();

  seq_det_ctrl #(.PAT_W(4), .CNT_W(8)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (sif)
  );

  typedef struct {
    int idx;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bidx   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit expm, input int ecnt, input logic stp);
    sif.bit_valid = 1'b1;
    sif.bit_in    = b;
    sif.stop      = stp;
    bidx++;
    if (expm) exp_q.push_back('{bidx, ecnt});
    #2;
    chk($sformatf("match_bit%0d", bidx), {31'd0, sif.match}, {31'd0, expm});
    tick();
    sif.bit_valid = 1'b0;
    sif.stop      = 1'b0;
  endtask

  task automatic gap(input logic b);
    sif.bit_valid = 1'b0;
    sif.bit_in    = b;
    tick();
  endtask

  task automatic start_run();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    bidx = 0;
  endtask

  task automatic do_stop();
    sif.stop = 1'b1;
    tick();
    sif.stop = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] pat, input logic [2:0] len, input logic [7:0] tgt);
    sif.cfg_valid   = 1'b1;
    sif.cfg_pattern = pat;
    sif.cfg_len     = len;
    sif.cfg_target  = tgt;
    tick();
    sif.cfg_valid = 1'b0;
  endtask

  // monitor: every asserted match must correspond to a queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sif.match === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_match: got match at bit %0d expected none", bidx);
        end else begin
          e = exp_q.pop_front();
          chk("match_bit_index", bidx, e.idx);
          @(posedge clk);
          #1;
          chk($sformatf("match_cnt_after_bit%0d", e.idx), {24'd0, sif.match_cnt}, e.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    clr             = 1'b0;
    sif.cfg_valid   = 1'b0;
    sif.cfg_pattern = '0;
    sif.cfg_len     = '0;
    sif.cfg_target  = '0;
    sif.start       = 1'b0;
    sif.stop        = 1'b0;
    sif.bit_valid   = 1'b0;
    sif.bit_in      = 1'b0;
    #1 clr = 1'b1;
    #2;
    chk("rst_busy", {31'd0, sif.busy}, 0);
    chk("rst_done", {31'd0, sif.done}, 0);
    chk("rst_match", {31'd0, sif.match}, 0);
    chk("rst_cfg_ready", {31'd0, sif.cfg_ready}, 1);
    chk("rst_match_cnt", {24'd0, sif.match_cnt}, 0);
    @(negedge clk);
    clr = 1'b0;
    tick();

    // default pattern 1010
    start_run();
    chk("t1_busy", {31'd0, sif.busy}, 1);
    chk("t1_cfg_ready", {31'd0, sif.cfg_ready}, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 1, 1, 0);
    chk("t1_cnt", {24'd0, sif.match_cnt}, 1);

    // 1010101, overlap-dependent
    do_stop();
    chk("t2_idle", {31'd0, sif.busy}, 0);
    start_run();
    chk("t2_cnt_cleared", {24'd0, sif.match_cnt}, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 1, 1, 0);
    send_bit(1, 0, 0, 0);
`ifdef SEQ_DET_OVERLAP_EN
    send_bit(0, 1, 2, 0);
    send_bit(1, 0, 0, 0);
    chk("t2_cnt", {24'd0, sif.match_cnt}, 2);
`else
    send_bit(0, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    chk("t2_cnt", {24'd0, sif.match_cnt}, 1);
`endif

    // pattern 110, len 3, target 2; start with config is ignored
    do_stop();
    sif.start = 1'b1;
    cfg(4'b0110, 3'd3, 8'd2);
    sif.start = 1'b0;
    chk("t3_start_ignored", {31'd0, sif.busy}, 0);
    start_run();
    send_bit(1, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 1, 1, 0);
    send_bit(1, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 1, 2, 0);
    chk("t3_done", {31'd0, sif.done}, 1);
    chk("t3_busy", {31'd0, sif.busy}, 0);
    chk("t3_cfg_ready", {31'd0, sif.cfg_ready}, 1);
    send_bit(1, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 0, 0, 0);
    chk("t3_cnt_hold", {24'd0, sif.match_cnt}, 2);

    // gapped stream; len 7 clamps to 4; idle slots carry bit_in=1
    cfg(4'b1010, 3'd7, 8'd0);
    start_run();
    send_bit(1, 0, 0, 0);
    gap(1);
    send_bit(0, 0, 0, 0);
    gap(1);
    send_bit(1, 0, 0, 0);
    gap(1);
    send_bit(0, 1, 1, 0);
    chk("t4_cnt", {24'd0, sif.match_cnt}, 1);

    // stop with the matching bit
    do_stop();
    start_run();
    send_bit(1, 0, 0, 0);
    send_bit(0, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 1, 0, 1);
    chk("t5_idle", {31'd0, sif.busy}, 0);
    chk("t5_cnt", {24'd0, sif.match_cnt}, 0);

    // config offered during RUN is ignored
    start_run();
    sif.cfg_valid   = 1'b1;
    sif.cfg_pattern = 4'b0110;
    sif.cfg_len     = 3'd3;
    sif.cfg_target  = 8'd1;
    #2;
    chk("t5_cfg_ready_run", {31'd0, sif.cfg_ready}, 0);
    tick();
    sif.cfg_valid = 1'b0;
    send_bit(1, 0, 0, 0);
    send_bit(0, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 1, 1, 0);
    chk("t5_still_busy", {31'd0, sif.busy}, 1);

    // clr mid-run
    send_bit(1, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    send_bit(0, 0, 0, 0);
    send_bit(1, 0, 0, 0);
    clr = 1'b1;
    #2;
    chk("t6_busy", {31'd0, sif.busy}, 0);
    chk("t6_done", {31'd0, sif.done}, 0);
    chk("t6_match", {31'd0, sif.match}, 0);
    chk("t6_cfg_ready", {31'd0, sif.cfg_ready}, 1);
    chk("t6_cnt", {24'd0, sif.match_cnt}, 0);
    @(negedge clk);
    clr = 1'b0;
    tick();
    start_run();
    send_bit(0, 0, 0, 0);
    chk("t6_cnt_after", {24'd0, sif.match_cnt}, 0);

    tick();
    tick();
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
